// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V data-memory load/store unit.
//   lsu_size_t          : access size as encoded on lsu_size_i
//   lsu_state_t         : LSU control FSM state encoding
//   LSU_TIMEOUT_DEFAULT : default cycle budget per memory beat
//   is_misaligned()     : true when an access crosses a 32-bit word boundary
package riscv_pkg;

   typedef enum logic [1:0] {
      Byte_Access     = 2'b00,
      Halfword_Access = 2'b01,
      Word_Access     = 2'b10,
      Reserved        = 2'b11   // behaves as a word access
   } lsu_size_t;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ISSUE = 2'b01,
      WAIT  = 2'b10,
      DONE  = 2'b11
   } lsu_state_t;

   localparam int LSU_TIMEOUT_DEFAULT = 16;

   function automatic logic is_misaligned(input lsu_size_t size, input logic [1:0] off);
      case (size)
         Byte_Access:     return 1'b0;
         Halfword_Access: return (off == 2'd3);
         default:         return (off != 2'd0);
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_lane_align.sv
// Combinational byte-lane steering for the LSU.
//   size_i, off_i, zero_ext_i : access size, address[1:0], load extension mode
//   wdata_i                   : right-aligned store data
//   rdata_lo_i / rdata_hi_i   : word read at the aligned address / at address+4
//   be_lo_o / be_hi_o         : byte enables for the first / second word
//   wdata_lo_o / wdata_hi_o   : lane-shifted store data for the first / second word
//   rdata_o                   : right-aligned, zero- or sign-extended load data
// The hi outputs and rdata_hi_i only matter when an access spans two words.
module riscv_lsu_lane_align
   import riscv_pkg::*;
(
   input  lsu_size_t   size_i,
   input  logic [1:0]  off_i,
   input  logic        zero_ext_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_lo_i,
   input  logic [31:0] rdata_hi_i,
   output logic [3:0]  be_lo_o,
   output logic [3:0]  be_hi_o,
   output logic [31:0] wdata_lo_o,
   output logic [31:0] wdata_hi_o,
   output logic [31:0] rdata_o
);

   logic [4:0]  lane_sh;
   logic [3:0]  be_base;
   logic [7:0]  be_wide;
   logic [63:0] wdata_wide;
   logic [31:0] rd_sh;

   always_comb begin
      lane_sh = {off_i, 3'b000};

      case (size_i)
         Byte_Access:     be_base = 4'b0001;
         Halfword_Access: be_base = 4'b0011;
         default:         be_base = 4'b1111;
      endcase

      // Shifting into an 8-lane / 64-bit window lets a word-crossing access
      // spill its upper lanes into the second word.
      be_wide               = {4'b0000, be_base} << off_i;
      {be_hi_o, be_lo_o}    = be_wide;
      wdata_wide            = {32'd0, wdata_i} << lane_sh;
      {wdata_hi_o, wdata_lo_o} = wdata_wide;

      // Bytes above the access size are replaced by the extension below, so
      // whatever the hi word contributes for a single-word access is harmless.
      rd_sh = 32'({rdata_hi_i, rdata_lo_i} >> lane_sh);

      case (size_i)
         Byte_Access:     rdata_o = {{24{~zero_ext_i & rd_sh[7]}},  rd_sh[7:0]};
         Halfword_Access: rdata_o = {{16{~zero_ext_i & rd_sh[15]}}, rd_sh[15:0]};
         default:         rdata_o = rd_sh;
      endcase
   end

endmodule

// File: rtl/riscv_data_mem_lsu.sv
// RISC-V data-memory load/store unit: takes one core access at a time, runs a
// request/grant + response handshake with memory and returns extended load
// data with a one-cycle done pulse.
//   Core side   : lsu_req_i, lsu_addr_i, lsu_size_i, lsu_wr_i, lsu_wdata_i,
//                 lsu_zero_extnd_i -> lsu_busy_o, lsu_done_o, lsu_rdata_o, lsu_err_o
//   Memory side : mem_req_o, mem_addr_o, mem_be_o, mem_wr_o, mem_wdata_o
//                 <- mem_gnt_i, mem_rvalid_i, mem_rdata_i
// Each beat (ISSUE + WAIT) may take at most TIMEOUT_CYC cycles; on expiry the
// access ends with lsu_err_o=1 and lsu_rdata_o=0.
// Build option: define RISCV_LSU_MISALIGN_SPLIT_EN to run word-crossing
// accesses as two beats; otherwise they complete immediately with an error.
module riscv_data_mem_lsu
   import riscv_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = LSU_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              lsu_req_i,
   input  logic [ADDR_W-1:0] lsu_addr_i,
   input  logic [1:0]        lsu_size_i,
   input  logic              lsu_wr_i,
   input  logic [31:0]       lsu_wdata_i,
   input  logic              lsu_zero_extnd_i,
   output logic              lsu_busy_o,
   output logic              lsu_done_o,
   output logic [31:0]       lsu_rdata_o,
   output logic              lsu_err_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic              mem_wr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvalid_i,
   input  logic [31:0]       mem_rdata_i
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [ADDR_W-3:0] WORD_ONE = (ADDR_W-2)'(1);

   lsu_state_t        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   lsu_size_t         size_q, size_d;
   logic              wr_q, wr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              zext_q, zext_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic              second_beat;
   logic              timeout_hit;
   logic [31:0]       rd_lo;
   logic [3:0]        be_lo, be_hi;
   logic [31:0]       wdata_lo, wdata_hi, rd_ext;

`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
   logic              beat_q, beat_d;   // 1 while running the address+4 beat
   logic [31:0]       lo_q, lo_d;       // first-beat read data awaiting merge
   logic              misaligned;

   assign misaligned  = is_misaligned(size_q, addr_q[1:0]);
   assign second_beat = beat_q;
   assign rd_lo       = beat_q ? lo_q : mem_rdata_i;
`else
   assign second_beat = 1'b0;
   assign rd_lo       = mem_rdata_i;
`endif

   // Counter is not cleared between ISSUE and WAIT: the budget covers the beat.
   assign timeout_hit = (cnt_q >= CNT_LAST);

   riscv_lsu_lane_align u_lane_align (
      .size_i     (size_q),
      .off_i      (addr_q[1:0]),
      .zero_ext_i (zext_q),
      .wdata_i    (wdata_q),
      .rdata_lo_i (rd_lo),
      .rdata_hi_i (mem_rdata_i),
      .be_lo_o    (be_lo),
      .be_hi_o    (be_hi),
      .wdata_lo_o (wdata_lo),
      .wdata_hi_o (wdata_hi),
      .rdata_o    (rd_ext)
   );

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      zext_d  = zext_q;
      rdata_d = rdata_q;
      err_d   = err_q;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
      beat_d  = beat_q;
      lo_d    = lo_q;
`endif

      case (state_q)
         IDLE: begin
            if (lsu_req_i) begin
               addr_d  = lsu_addr_i;
               size_d  = lsu_size_t'(lsu_size_i);
               wr_d    = lsu_wr_i;
               wdata_d = lsu_wdata_i;
               zext_d  = lsu_zero_extnd_i;
               cnt_d   = '0;
               rdata_d = '0;
               err_d   = 1'b0;
               state_d = ISSUE;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
               beat_d  = 1'b0;
`else
               if (is_misaligned(lsu_size_t'(lsu_size_i), lsu_addr_i[1:0])) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
`endif
            end
         end

         ISSUE: begin
            cnt_d = cnt_q + CNT_ONE;
            if (mem_gnt_i) begin
               state_d = WAIT;
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = DONE;
            end
         end

         WAIT: begin
            cnt_d = cnt_q + CNT_ONE;
            if (mem_rvalid_i) begin
               rdata_d = wr_q ? 32'd0 : rd_ext;
               state_d = DONE;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
               if (misaligned && !beat_q) begin
                  lo_d    = mem_rdata_i;
                  beat_d  = 1'b1;
                  cnt_d   = '0;
                  rdata_d = rdata_q;
                  state_d = ISSUE;
               end
`endif
            end else if (timeout_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               state_d = DONE;
            end
         end

         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: asynchronous reset clears every register, including the in-flight
   // request context, so a late response after reset lands in IDLE and is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         size_q  <= Byte_Access;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         zext_q  <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
         beat_q  <= 1'b0;
         lo_q    <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so all state updates see pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         zext_q  <= zext_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
         beat_q  <= beat_d;
         lo_q    <= lo_d;
`endif
      end
   end

   // Memory channel is forced to zero whenever no request is presented.
   always_comb begin
      mem_req_o   = (state_q == ISSUE);
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      mem_wr_o    = 1'b0;
      if (mem_req_o) begin
         mem_addr_o  = second_beat ? {addr_q[ADDR_W-1:2] + WORD_ONE, 2'b00}
                                   : {addr_q[ADDR_W-1:2], 2'b00};
         mem_be_o    = second_beat ? be_hi : be_lo;
         mem_wdata_o = second_beat ? wdata_hi : wdata_lo;
         mem_wr_o    = wr_q;
      end
      lsu_busy_o  = (state_q == ISSUE) || (state_q == WAIT);
      lsu_done_o  = (state_q == DONE);
      lsu_rdata_o = lsu_done_o ? rdata_q : 32'd0;
      lsu_err_o   = lsu_done_o ? err_q : 1'b0;
   end

endmodule

// File: tb/tb_riscv_data_mem_lsu.sv
// Directed self-checking bench for riscv_data_mem_lsu. Inputs change on the
// falling edge and outputs are sampled on the falling edge; "cycle N" is the
// cycle after the Nth rising edge following the request-sampling edge 0.
module tb_riscv_data_mem_lsu;

   localparam int ADDR_W = 32;
   localparam int TO     = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              lsu_req_i, lsu_wr_i, lsu_zero_extnd_i;
   logic [ADDR_W-1:0] lsu_addr_i;
   logic [1:0]        lsu_size_i;
   logic [31:0]       lsu_wdata_i;
   logic              lsu_busy_o, lsu_done_o, lsu_err_o;
   logic [31:0]       lsu_rdata_o;
   logic              mem_req_o, mem_wr_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [3:0]        mem_be_o;
   logic [31:0]       mem_wdata_o;
   logic              mem_gnt_i, mem_rvalid_i;
   logic [31:0]       mem_rdata_i;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   riscv_data_mem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .lsu_req_i        (lsu_req_i),
      .lsu_addr_i       (lsu_addr_i),
      .lsu_size_i       (lsu_size_i),
      .lsu_wr_i         (lsu_wr_i),
      .lsu_wdata_i      (lsu_wdata_i),
      .lsu_zero_extnd_i (lsu_zero_extnd_i),
      .lsu_busy_o       (lsu_busy_o),
      .lsu_done_o       (lsu_done_o),
      .lsu_rdata_o      (lsu_rdata_o),
      .lsu_err_o        (lsu_err_o),
      .mem_req_o        (mem_req_o),
      .mem_addr_o       (mem_addr_o),
      .mem_be_o         (mem_be_o),
      .mem_wr_o         (mem_wr_o),
      .mem_wdata_o      (mem_wdata_o),
      .mem_gnt_i        (mem_gnt_i),
      .mem_rvalid_i     (mem_rvalid_i),
      .mem_rdata_i      (mem_rdata_i)
   );

   // Presents a request for one cycle; returns at the falling edge of cycle 1.
   task automatic start_req(input logic [31:0] addr, input logic [1:0] size,
                            input logic wr, input logic [31:0] wdata, input logic zext);
      @(negedge clk);
      lsu_addr_i = addr; lsu_size_i = size; lsu_wr_i = wr;
      lsu_wdata_i = wdata; lsu_zero_extnd_i = zext; lsu_req_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lsu_req_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; lsu_req_i = 1'b1; lsu_addr_i = 32'h10; lsu_size_i = 2'b10;
      lsu_wr_i = 1'b1; lsu_wdata_i = 32'hFFFF_FFFF; lsu_zero_extnd_i = 1'b0;
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      n_cmp++; if ({lsu_busy_o, lsu_done_o, lsu_err_o, mem_req_o, mem_wr_o} !== 5'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 00000", {lsu_busy_o, lsu_done_o, lsu_err_o, mem_req_o, mem_wr_o}); end
      n_cmp++; if ({lsu_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o} !== '0) begin n_bad++; $display("FAIL rst_data: rdata %h addr %h wdata %h be %b want all 0", lsu_rdata_o, mem_addr_o, mem_wdata_o, mem_be_o); end
      lsu_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (lsu_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_idle: busy %b req %b want 0 0", lsu_busy_o, mem_req_o); end
   endtask

   task automatic test_load_byte();
      start_req(32'h1003, 2'b00, 1'b0, 32'h0, 1'b0);
      n_cmp++; if (mem_req_o !== 1'b1 || lsu_busy_o !== 1'b1) begin n_bad++; $display("FAIL lb_c1: req %b busy %b want 1 1", mem_req_o, lsu_busy_o); end
      n_cmp++; if (mem_addr_o !== 32'h1000) begin n_bad++; $display("FAIL lb_addr: got %h want 00001000", mem_addr_o); end
      n_cmp++; if (mem_be_o !== 4'b1000) begin n_bad++; $display("FAIL lb_be: got %b want 1000", mem_be_o); end
      n_cmp++; if (mem_wr_o !== 1'b0) begin n_bad++; $display("FAIL lb_wr: got %b want 0", mem_wr_o); end
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0;
      n_cmp++; if (mem_req_o !== 1'b0 || lsu_busy_o !== 1'b1 || lsu_done_o !== 1'b0) begin n_bad++; $display("FAIL lb_c2: req %b busy %b done %b want 0 1 0", mem_req_o, lsu_busy_o, lsu_done_o); end
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'h8012_3456;
      @(negedge clk); mem_rvalid_i = 1'b0;
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_busy_o !== 1'b0 || lsu_err_o !== 1'b0) begin n_bad++; $display("FAIL lb_c3: done %b busy %b err %b want 1 0 0", lsu_done_o, lsu_busy_o, lsu_err_o); end
      n_cmp++; if (lsu_rdata_o !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want ffffff80", lsu_rdata_o); end
      @(negedge clk);
      n_cmp++; if (lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'h0) begin n_bad++; $display("FAIL lb_c4: done %b rdata %h want 0 0", lsu_done_o, lsu_rdata_o); end
   endtask

   typedef struct packed {
      logic [31:0] addr;
      logic [1:0]  size;
      logic        zext;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic [31:0] exp;
   } ld_vec_t;

   task automatic test_load_lanes();
      ld_vec_t v [8];
      v[0] = '{32'h0000_0002, 2'b01, 1'b1, 32'h9ABC_1234, 4'b1100, 32'h0000_9ABC};
      v[1] = '{32'h0000_0000, 2'b01, 1'b0, 32'h1234_F00D, 4'b0011, 32'hFFFF_F00D};
      v[2] = '{32'h0000_0001, 2'b00, 1'b1, 32'h0000_A500, 4'b0010, 32'h0000_00A5};
      v[3] = '{32'h0000_0004, 2'b10, 1'b0, 32'hCAFE_BABE, 4'b1111, 32'hCAFE_BABE};
      v[4] = '{32'h0000_0008, 2'b11, 1'b0, 32'h8765_4321, 4'b1111, 32'h8765_4321};
      v[5] = '{32'h0000_0001, 2'b01, 1'b0, 32'h00C3_D200, 4'b0110, 32'hFFFF_C3D2};
      v[6] = '{32'h0000_0003, 2'b00, 1'b1, 32'hFF00_0000, 4'b1000, 32'h0000_00FF};
      v[7] = '{32'h0000_0002, 2'b00, 1'b0, 32'h007F_0000, 4'b0100, 32'h0000_007F};
      for (int i = 0; i < 8; i++) begin
         start_req(v[i].addr, v[i].size, 1'b0, 32'h0, v[i].zext);
         n_cmp++; if (mem_be_o !== v[i].be || mem_addr_o !== {v[i].addr[31:2], 2'b00}) begin n_bad++; $display("FAIL ld%0d_lane: be %b addr %h want %b %h", i, mem_be_o, mem_addr_o, v[i].be, {v[i].addr[31:2], 2'b00}); end
         mem_gnt_i = 1'b1;
         @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = v[i].rdata;
         @(negedge clk); mem_rvalid_i = 1'b0;
         n_cmp++; if (lsu_done_o !== 1'b1 || lsu_rdata_o !== v[i].exp) begin n_bad++; $display("FAIL ld%0d_rdata: done %b rdata %h want 1 %h", i, lsu_done_o, lsu_rdata_o, v[i].exp); end
      end
   endtask

   task automatic test_store_half();
      start_req(32'h2002, 2'b01, 1'b1, 32'h0000_BEEF, 1'b0);
      n_cmp++; if (mem_be_o !== 4'b1100 || mem_wdata_o !== 32'hBEEF_0000) begin n_bad++; $display("FAIL sh_lane: be %b wdata %h want 1100 beef0000", mem_be_o, mem_wdata_o); end
      n_cmp++; if (mem_wr_o !== 1'b1 || mem_addr_o !== 32'h2000) begin n_bad++; $display("FAIL sh_req: wr %b addr %h want 1 00002000", mem_wr_o, mem_addr_o); end
      // A new request while busy must not disturb the latched access.
      lsu_req_i = 1'b1; lsu_addr_i = 32'hDEAD_0000; lsu_wdata_i = 32'h1234_5678;
      @(negedge clk);
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2000 || mem_wdata_o !== 32'hBEEF_0000) begin n_bad++; $display("FAIL sh_hold: req %b addr %h wdata %h want 1 00002000 beef0000", mem_req_o, mem_addr_o, mem_wdata_o); end
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0; lsu_req_i = 1'b0;
      mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
      @(negedge clk); mem_rvalid_i = 1'b0;
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_rdata_o !== 32'h0 || lsu_err_o !== 1'b0) begin n_bad++; $display("FAIL sh_done: done %b rdata %h err %b want 1 0 0", lsu_done_o, lsu_rdata_o, lsu_err_o); end
      @(negedge clk);
      n_cmp++; if (lsu_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL sh_idle: busy %b req %b want 0 0", lsu_busy_o, mem_req_o); end
   endtask

   // Grant withheld: ISSUE occupies cycles 1..TO, DONE with error in cycle TO+1.
   task automatic test_timeout_issue();
      logic ok;
      ok = 1'b1;
      start_req(32'h4000, 2'b10, 1'b0, 32'h0, 1'b0);
      for (int c = 1; c <= TO; c++) begin
         if (mem_req_o !== 1'b1 || lsu_done_o !== 1'b0) ok = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL to_hold: req/done wrong before timeout, got ok=%b want 1", ok); end
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rdata_o !== 32'h0 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL to_done: done %b err %b rdata %h req %b want 1 1 0 0", lsu_done_o, lsu_err_o, lsu_rdata_o, mem_req_o); end
      repeat (4) @(negedge clk);
      n_cmp++; if (lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL to_idle: done %b busy %b req %b want 0 0 0", lsu_done_o, lsu_busy_o, mem_req_o); end
   endtask

   // Budget spans ISSUE+WAIT: response in cycle TO is accepted, none ends in error.
   task automatic test_timeout_wait();
      logic ok;
      for (int k = 0; k < 2; k++) begin
         ok = 1'b1;
         start_req(32'h4004, 2'b10, 1'b0, 32'h0, 1'b0);
         mem_gnt_i = 1'b1;
         @(negedge clk); mem_gnt_i = 1'b0;
         for (int c = 2; c < TO; c++) begin
            if (lsu_busy_o !== 1'b1 || lsu_done_o !== 1'b0) ok = 1'b0;
            @(negedge clk);
         end
         mem_rvalid_i = (k == 0); mem_rdata_i = 32'h0BAD_F00D;
         @(negedge clk); mem_rvalid_i = 1'b0;
         n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL tw%0d_hold: early done or not busy, got ok=%b want 1", k, ok); end
         if (k == 0) begin
            n_cmp++; if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL tw_late_ok: done %b err %b rdata %h want 1 0 0badf00d", lsu_done_o, lsu_err_o, lsu_rdata_o); end
         end else begin
            n_cmp++; if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rdata_o !== 32'h0) begin n_bad++; $display("FAIL tw_expire: done %b err %b rdata %h want 1 1 0", lsu_done_o, lsu_err_o, lsu_rdata_o); end
         end
      end
   endtask

   task automatic test_misaligned();
`ifdef RISCV_LSU_MISALIGN_SPLIT_EN
      start_req(32'h3001, 2'b10, 1'b0, 32'h0, 1'b0);
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h3000 || mem_be_o !== 4'b1110) begin n_bad++; $display("FAIL ms_b1: req %b addr %h be %b want 1 00003000 1110", mem_req_o, mem_addr_o, mem_be_o); end
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDDCC_BBAA;
      @(negedge clk); mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h3004 || mem_be_o !== 4'b0001 || lsu_done_o !== 1'b0) begin n_bad++; $display("FAIL ms_b2: req %b addr %h be %b done %b want 1 00003004 0001 0", mem_req_o, mem_addr_o, mem_be_o, lsu_done_o); end
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1122_3344;
      @(negedge clk); mem_rvalid_i = 1'b0;
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== 32'h44DD_CCBB) begin n_bad++; $display("FAIL ms_load: done %b err %b rdata %h want 1 0 44ddccbb", lsu_done_o, lsu_err_o, lsu_rdata_o); end
      start_req(32'h5002, 2'b10, 1'b1, 32'hAABB_CCDD, 1'b0);
      n_cmp++; if (mem_addr_o !== 32'h5000 || mem_be_o !== 4'b1100 || mem_wdata_o !== 32'hCCDD_0000) begin n_bad++; $display("FAIL ms_st1: addr %h be %b wdata %h want 00005000 1100 ccdd0000", mem_addr_o, mem_be_o, mem_wdata_o); end
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
      @(negedge clk); mem_rvalid_i = 1'b0;
      n_cmp++; if (mem_addr_o !== 32'h5004 || mem_be_o !== 4'b0011 || mem_wdata_o !== 32'h0000_AABB) begin n_bad++; $display("FAIL ms_st2: addr %h be %b wdata %h want 00005004 0011 0000aabb", mem_addr_o, mem_be_o, mem_wdata_o); end
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
      @(negedge clk); mem_rvalid_i = 1'b0;
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_rdata_o !== 32'h0 || lsu_err_o !== 1'b0) begin n_bad++; $display("FAIL ms_st_done: done %b rdata %h err %b want 1 0 0", lsu_done_o, lsu_rdata_o, lsu_err_o); end
`else
      start_req(32'h3001, 2'b10, 1'b0, 32'h0, 1'b0);
      mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDDCC_BBAA;
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b1 || lsu_rdata_o !== 32'h0) begin n_bad++; $display("FAIL ms_err: done %b err %b rdata %h want 1 1 0", lsu_done_o, lsu_err_o, lsu_rdata_o); end
      n_cmp++; if (mem_req_o !== 1'b0 || lsu_busy_o !== 1'b0) begin n_bad++; $display("FAIL ms_noreq: req %b busy %b want 0 0", mem_req_o, lsu_busy_o); end
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      n_cmp++; if (mem_req_o !== 1'b0 || lsu_done_o !== 1'b0) begin n_bad++; $display("FAIL ms_after: req %b done %b want 0 0", mem_req_o, lsu_done_o); end
      start_req(32'h5003, 2'b01, 1'b1, 32'h0000_1234, 1'b0);
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b1 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL ms_half3: done %b err %b req %b want 1 1 0", lsu_done_o, lsu_err_o, mem_req_o); end
`endif
   endtask

   task automatic test_reset_mid();
      start_req(32'h6000, 2'b10, 1'b0, 32'h0, 1'b0);
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0;
      n_cmp++; if (lsu_busy_o !== 1'b1) begin n_bad++; $display("FAIL rm_pre: busy %b want 1", lsu_busy_o); end
      reset_n = 1'b0;
      #1;
      n_cmp++; if (lsu_busy_o !== 1'b0 || mem_req_o !== 1'b0 || lsu_done_o !== 1'b0) begin n_bad++; $display("FAIL rm_async: busy %b req %b done %b want 0 0 0", lsu_busy_o, mem_req_o, lsu_done_o); end
      @(negedge clk); reset_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1234_5678;
      @(negedge clk); mem_rvalid_i = 1'b0;
      n_cmp++; if (lsu_done_o !== 1'b0 || lsu_rdata_o !== 32'h0 || lsu_busy_o !== 1'b0) begin n_bad++; $display("FAIL rm_late: done %b rdata %h busy %b want 0 0 0", lsu_done_o, lsu_rdata_o, lsu_busy_o); end
      @(negedge clk);
      n_cmp++; if (lsu_done_o !== 1'b0 || mem_req_o !== 1'b0) begin n_bad++; $display("FAIL rm_quiet: done %b req %b want 0 0", lsu_done_o, mem_req_o); end
      start_req(32'h6008, 2'b10, 1'b0, 32'h0, 1'b0);
      n_cmp++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h6008) begin n_bad++; $display("FAIL rm_next_req: req %b addr %h want 1 00006008", mem_req_o, mem_addr_o); end
      mem_gnt_i = 1'b1;
      @(negedge clk); mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A_A5A5;
      @(negedge clk); mem_rvalid_i = 1'b0;
      n_cmp++; if (lsu_done_o !== 1'b1 || lsu_rdata_o !== 32'h5A5A_A5A5 || lsu_err_o !== 1'b0) begin n_bad++; $display("FAIL rm_next_done: done %b rdata %h err %b want 1 5a5aa5a5 0", lsu_done_o, lsu_rdata_o, lsu_err_o); end
   endtask

   initial begin
      test_reset();
      test_load_byte();
      test_load_lanes();
      test_store_half();
      test_timeout_issue();
      test_timeout_wait();
      test_misaligned();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/riscv_data_mem_lsu.md
RISCV_DATA_MEM_LSU -- requirements
Module: riscv_data_mem_lsu

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width in bits.
REQ-002 Parameter TIMEOUT_CYC, default 16, sets the maximum cycles per beat from request to mem_rvalid_i.
REQ-003 Ports, in order:
- clk  in  1  clock, rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- lsu_req_i  in  1  core access request.
- lsu_addr_i  in  ADDR_W  byte address.
- lsu_size_i  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- lsu_wr_i  in  1  1 = store, 0 = load.
- lsu_wdata_i  in  32  store data, right-aligned.
- lsu_zero_extnd_i  in  1  1 = zero-extend load, 0 = sign-extend load.
- lsu_busy_o  out  1  transaction in flight; core stalls.
- lsu_done_o  out  1  one-cycle completion pulse.
- lsu_rdata_o  out  32  extended load data, valid while lsu_done_o is high.
- lsu_err_o  out  1  error, qualified by lsu_done_o.
- mem_req_o, mem_addr_o[ADDR_W], mem_be_o[4], mem_wr_o, mem_wdata_o[32]  out  memory request channel; mem_addr_o[1:0] = 0.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  response; used for loads and stores.
- mem_rdata_i  in  32  load data, aligned to word lanes.

Function
REQ-004 States: IDLE, ISSUE, WAIT, DONE; encoding is a package enum.
REQ-005 IDLE with lsu_req_i=1: latch all lsu_* inputs and go to ISSUE; lsu_busy_o=1 from the next cycle until DONE completes.
REQ-006 lsu_req_i is ignored outside IDLE.
REQ-007 ISSUE: hold mem_req_o=1 with stable address, byte enables and write data; mem_gnt_i=1 moves the FSM to WAIT.
REQ-008 WAIT: mem_rvalid_i=1 completes the beat; mem_rvalid_i is ignored in every other state.
REQ-009 Byte-lane rules, with off = addr[1:0]:
- mem_be_o = (0001 / 0011 / 1111 by size) << off, truncated to 4 bits.
- mem_wdata_o = lsu_wdata_i << 8*off.
- Load data = mem_rdata_i >> 8*off, then zero- or sign-extended from bit 7 or bit 15 per size.
REQ-010 Misaligned access = half with off=3, or word with off!=0.
REQ-011 DONE lasts one cycle: lsu_done_o=1, lsu_busy_o=0, then the FSM goes to IDLE. Registered rdata and err are shown in DONE only.
REQ-012 Minimum aligned latency: request sampled at edge 0; mem_req_o high in cycle 1; mem_gnt_i in cycle 1; mem_rvalid_i in cycle 2; lsu_done_o in cycle 3.
REQ-013 A per-beat counter clears on entry to ISSUE and increments in ISSUE and WAIT. On reaching TIMEOUT_CYC: go to DONE with lsu_err_o=1, lsu_rdata_o=0, and drop mem_req_o.
REQ-014 Store completion returns lsu_rdata_o=0.

Reset
REQ-015 reset_n low forces the IDLE state and sets every output and internal register to 0, mid-transaction included.
REQ-016 A memory response that arrives after reset for a request issued before reset is ignored.

Configuration
REQ-017 Macro RISCV_LSU_MISALIGN_SPLIT_EN, when defined, handles misaligned accesses as two beats.
- Beat 1: aligned address, upper lanes.
- Beat 2: address+4, remaining lanes, with data shifted accordingly.
- Load bytes from both beats are merged before extension; lsu_done_o fires once, after beat 2.
- Each beat has its own timeout; a beat-1 timeout skips beat 2.
REQ-018 When the macro is undefined, a misaligned request issues no mem_req_o and goes straight to DONE with lsu_err_o=1.

Structure
REQ-019 riscv_pkg holds:
- the access-size enum (Byte_Access, Halfword_Access, Word_Access, Reserved);
- lsu_state_t;
- LSU_TIMEOUT_DEFAULT.
REQ-020 Combinational sub-module riscv_lsu_lane_align performs the write shift, byte-enable generation, read shift/merge and extension.

Verification
REQ-021 Load byte, addr 0x1003, sign-extend, mem_rdata_i=0x80xxxxxx -> mem_be_o=1000, lsu_rdata_o=0xFFFFFF80, done in cycle 3.
REQ-022 Store half, addr 0x2002, wdata 0x0000BEEF -> mem_be_o=1100, mem_wdata_o=0xBEEF0000, lsu_rdata_o=0.
REQ-023 mem_gnt_i held low for 20 cycles -> lsu_err_o=1 with done at TIMEOUT_CYC, mem_req_o dropped, FSM in IDLE.
REQ-024 Load word, addr 0x3001, beat 1 reads 0xDDCCBBAA, beat 2 reads 0x11223344:
- with macro: beats at 0x3000/1110 then 0x3004/0001, lsu_rdata_o=0x44DDCCBB;
- without macro: lsu_err_o=1 and no mem_req_o.
REQ-025 reset_n pulsed low during WAIT, then a late mem_rvalid_i -> outputs 0, no lsu_done_o; the next request completes normally.
